dac_spi_tx: RTL
===============

Name: dac_spi_tx

Overview:
- Serializer stage directly downstream of the serial-clock divider (sysclk/4, 50% duty).
- Takes a 12-bit sample from the ADC capture path and shifts it out as one 16-bit frame to the Pmod DAC (DAC121S101-class): 2 don't-care bits, 2 power-down bits = 00, then 12 data bits, MSB first.
- Runs entirely on the system clock. It treats the divided serial clock as a level input, detects its edges internally, and generates the active-low frame sync and the data line.

Parameters:
- DATA_BITS, 12, width of data_in.
- FRAME_BITS, 16, bits per frame. The leading FRAME_BITS-DATA_BITS bits are 0.
- QUIET_EDGES, 2, minimum sclk rising edges with sync_n high between frames. Legal range 1..15.

Ports:
- clock  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- sclk1  input  1  divided serial clock from the divider stage; also routed to the DAC pin outside this block.
- data_in  input  DATA_BITS  sample to transmit; sampled only on an accepted load.
- load  input  1  request to send data_in; accepted only when ready=1.
- ready  output  1  high when idle and able to accept load.
- sync_n  output  1  DAC frame sync, active low.
- dout  output  1  serial data to DAC, MSB first.
- done  output  1  one-clock pulse at frame completion.

Behaviour:
- Reset values: ready=1, sync_n=1, dout=0, done=0, state=IDLE, shift register=0, bit counter=0. Internal sclk1 delay register=0.
- Edge detect uses a registered copy of sclk1, sclk_d.
  - rise = sclk1 & ~sclk_d.
  - fall = ~sclk1 & sclk_d.
  - Detection lags the true edge by one clock. This is acceptable: the DAC samples on the falling edge and dout changes only after a detected rise.
- IDLE:
  - Outputs: ready=1, sync_n=1, dout=0.
  - On load=1, the block latches shift = {(FRAME_BITS-DATA_BITS) zeros, data_in}, sets ready=0 on the next clock and moves to ARM.
  - A load that arrives in the same clock as reset is ignored.
- ARM:
  - Waits for a detected rise.
  - On that rise it sets sync_n<=0, dout<=shift[FRAME_BITS-1], shifts left one bit, sets bit counter<=FRAME_BITS-1, and moves to SHIFT.
- SHIFT:
  - On each detected rise: dout<=shift MSB, shift left, decrement the counter.
  - On a detected fall with counter==0 (the 16th falling edge since sync_n fell): sync_n<=1, dout<=0, quiet counter<=0, move to QUIET.
  - Result: sync_n is low across exactly FRAME_BITS falling edges of sclk1. dout is stable across every falling edge.
- QUIET:
  - sync_n stays 1.
  - Each detected rise increments the quiet counter.
  - When the count reaches QUIET_EDGES: done=1 for one clock, ready<=1, move to IDLE.
- Busy handling: load while ready=0 is ignored and does not corrupt the frame. data_in changes while busy have no effect.
- Back-to-back frames: a load in the clock after done is accepted. The minimum frame-to-frame spacing is therefore set by QUIET_EDGES.
- Reset mid-frame:
  - The next clock forces sync_n=1, dout=0, ready=1, IDLE.
  - The partial frame is aborted; the DAC discards it because sync rises before the 16th edge.
  - No done pulse is produced.
- Stalled sclk1 (constant level): the FSM holds its state indefinitely. There is no timeout.
- Timing with the /4 divider, from an accepted load:
  - sync_n falls 2..5 clocks after load.
  - sync_n stays low about 62 clocks.
  - done follows sync_n rising by about QUIET_EDGES*4 clocks.
  - Total frame time is 80 clocks max with default parameters.

Test Plan:
- Reset, then idle for 20 clocks with a running /4 sclk1 -> ready=1, sync_n=1, dout=0, done=0 throughout.
- load with data_in=0xABC -> capture bits on the sclk1 falling edges while sync_n=0. Required: exactly 16 bits, 0000_1010_1011_1100. One done pulse, then ready=1.
- Extremes: data_in=0x000 then 0xFFF, loaded in the clock after each done -> frames 0x0000 and 0x0FFF. sync_n stays high for at least 2 sclk1 rising edges between frames.
- load=1 held continuously with data_in changing every clock -> each frame carries the value present at its accepting clock only. No frame is truncated or merged.
- Assert reset during the 7th bit of a frame -> next clock: sync_n=1, dout=0, ready=1. No done. A following load of 0x123 transmits a correct complete frame.
- Stop sclk1 (hold low) mid-frame for 50 clocks, then resume -> the frame continues from the held bit. Total falling edges with sync_n low = 16.

Source files
------------

// File: rtl/dac_spi_tx.sv
// Serializes one sample into a 16-bit DAC121S101-style frame (zero prefix, then data MSB first).
// The divided serial clock is treated as a level; its edges are detected on the system clock.
module dac_spi_tx #(
    parameter int DATA_BITS   = 12,
    parameter int FRAME_BITS  = 16,
    parameter int QUIET_EDGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sclk1,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 sync_n,
    output logic                 dout,
    output logic                 done
);

    localparam int CNT_W = $clog2(FRAME_BITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_QUIET = 2'd3;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [3:0]       QUIET_LAST = 4'(QUIET_EDGES - 1);

    logic [1:0]            state_q,   state_d;
    logic [FRAME_BITS-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]            quiet_q,   quiet_d;
    logic                  ready_q,   ready_d;
    logic                  sync_n_q,  sync_n_d;
    logic                  dout_q,    dout_d;
    logic                  done_q,    done_d;
    logic                  sclk_d_q;
    logic                  rise, fall;

    // Edge detection lags the pin by one clock; dout only moves after a rise,
    // so it is always settled well before the DAC samples on the fall.
    assign rise = sclk1 & ~sclk_d_q;
    assign fall = ~sclk1 & sclk_d_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        quiet_d   = quiet_q;
        ready_d   = ready_q;
        sync_n_d  = sync_n_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d = {{(FRAME_BITS-DATA_BITS){1'b0}}, data_in};
                    ready_d = 1'b0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (rise) begin
                    sync_n_d  = 1'b0;
                    dout_d    = shift_q[FRAME_BITS-1];
                    shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = BIT_LAST;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (rise) begin
                    dout_d    = shift_q[FRAME_BITS-1];
                    shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (fall && (bit_cnt_q == '0)) begin
                    // Last falling edge of the frame has been seen by the DAC.
                    sync_n_d = 1'b1;
                    dout_d   = 1'b0;
                    quiet_d  = '0;
                    state_d  = S_QUIET;
                end
            end
            S_QUIET: begin
                if (rise) begin
                    if (quiet_q == QUIET_LAST) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        quiet_d = quiet_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            quiet_q   <= '0;
            ready_q   <= 1'b1;
            sync_n_q  <= 1'b1;
            dout_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            quiet_q   <= quiet_d;
            ready_q   <= ready_d;
            sync_n_q  <= sync_n_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            sclk_d_q  <= sclk1;
        end
    end

    assign ready  = ready_q;
    assign sync_n = sync_n_q;
    assign dout   = dout_q;
    assign done   = done_q;

endmodule
